// File: rtl/snitch_icache_refill_writer.sv
// Refill writer behind the icache lookup stage: forwards hits, services one miss at a time
// by fetching the line, writing it back with its tag into a round-robin victim set, then responding.
module snitch_icache_refill_writer #(
  parameter int unsigned FETCH_AW    = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned LINE_COUNT  = 64,
  parameter int unsigned SET_COUNT   = 2,
  parameter int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8),
  parameter int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
  parameter int unsigned SET_ALIGN   = $clog2(SET_COUNT),
  parameter int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  input  logic [FETCH_AW-1:0]    lookup_addr_i,
  input  logic [ID_WIDTH-1:0]    lookup_id_i,
  input  logic [SET_ALIGN-1:0]   lookup_set_i,
  input  logic                   lookup_hit_i,
  input  logic [LINE_WIDTH-1:0]  lookup_data_i,
  input  logic                   lookup_error_i,
  input  logic                   lookup_valid_i,
  output logic                   lookup_ready_o,
  output logic [FETCH_AW-1:0]    refill_addr_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_error_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i
);

  // Handshake rule on every port pair: a transfer happens in a cycle where valid && ready;
  // a raised valid stays up with unchanged payload until that cycle.

  localparam int unsigned LW = FETCH_AW - LINE_ALIGN;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, RESP} state_e;

  state_e                state_q, state_d;
  logic [SET_ALIGN-1:0]  victim_q, victim_d;
  logic [SET_ALIGN-1:0]  miss_set_q, miss_set_d;
  logic [LW-1:0]         miss_line_q, miss_line_d;
  logic [ID_WIDTH-1:0]   miss_id_q, miss_id_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  error_q, error_d;
  logic                  skip_inc_q, skip_inc_d;

  // Hit set and in-line byte offset carry no information for the refill path.
  logic unused_inputs;
  assign unused_inputs = ^{lookup_set_i, lookup_addr_i[LINE_ALIGN-1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      victim_q    <= '0;
      miss_set_q  <= '0;
      miss_line_q <= '0;
      miss_id_q   <= '0;
      data_q      <= '0;
      error_q     <= 1'b0;
      skip_inc_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      miss_set_q  <= miss_set_d;
      miss_line_q <= miss_line_d;
      miss_id_q   <= miss_id_d;
      data_q      <= data_d;
      error_q     <= error_d;
      skip_inc_q  <= skip_inc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    miss_set_d  = miss_set_q;
    miss_line_d = miss_line_q;
    miss_id_d   = miss_id_q;
    data_d      = data_q;
    error_d     = error_q;
    skip_inc_d  = skip_inc_q;
    case (state_q)
      IDLE: begin
        if (flush_valid_i) victim_d = '0;
        // A flush in the capture cycle replaces this miss's later increment with the reset.
        if (lookup_valid_i && !lookup_hit_i) begin
          miss_line_d = lookup_addr_i[FETCH_AW-1:LINE_ALIGN];
          miss_id_d   = lookup_id_i;
          miss_set_d  = victim_q;
          skip_inc_d  = flush_valid_i;
          state_d     = REQ;
        end
      end
      REQ:   if (refill_ready_i) state_d = WAIT;
      WAIT: begin
        if (refill_valid_i) begin
          data_d  = refill_data_i;
          error_d = refill_error_i;
          state_d = WRITE;
        end
      end
      WRITE: if (write_ready_i) state_d = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          if (!skip_inc_q) victim_d = victim_q + SET_ALIGN'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_ready_o  = 1'b0;
    lookup_ready_o = 1'b0;
    refill_valid_o = 1'b0;
    refill_ready_o = 1'b0;
    write_valid_o  = 1'b0;
    rsp_valid_o    = 1'b0;
    refill_addr_o  = {miss_line_q, {LINE_ALIGN{1'b0}}};
    write_addr_o   = miss_line_q[COUNT_ALIGN-1:0];
    write_tag_o    = miss_line_q[LW-1 -: TAG_WIDTH];
    write_set_o    = miss_set_q;
    write_data_o   = data_q;
    write_error_o  = error_q;
    rsp_data_o     = data_q;
    rsp_id_o       = miss_id_q;
    rsp_error_o    = error_q;
    case (state_q)
      IDLE: begin
        // Reset holds the FSM in IDLE; keep its combinational handshakes quiet meanwhile.
        flush_ready_o = !rst_i;
        if (lookup_valid_i && !rst_i) begin
          if (lookup_hit_i) begin
            rsp_valid_o    = 1'b1;
            rsp_data_o     = lookup_data_i;
            rsp_id_o       = lookup_id_i;
            rsp_error_o    = lookup_error_i;
            lookup_ready_o = rsp_ready_i;
          end else begin
            lookup_ready_o = 1'b1;
          end
        end
      end
      REQ:     refill_valid_o = 1'b1;
      WAIT:    refill_ready_o = 1'b1;
      WRITE:   write_valid_o  = 1'b1;
      RESP:    rsp_valid_o    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Directed bench for snitch_icache_refill_writer: hit pass-through, miss flows, victim
// rotation, refill error, backpressure, flush and mid-miss reset.
module tb_snitch_icache_refill_writer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_valid_i, flush_ready_o;
  logic [31:0]  lookup_addr_i;
  logic [3:0]   lookup_id_i;
  logic [0:0]   lookup_set_i;
  logic         lookup_hit_i, lookup_error_i, lookup_valid_i, lookup_ready_o;
  logic [127:0] lookup_data_i;
  logic [31:0]  refill_addr_o;
  logic         refill_valid_o, refill_ready_i;
  logic [127:0] refill_data_i;
  logic         refill_error_i, refill_valid_i, refill_ready_o;
  logic [5:0]   write_addr_o;
  logic [0:0]   write_set_o;
  logic [127:0] write_data_o;
  logic [21:0]  write_tag_o;
  logic         write_error_o, write_valid_o, write_ready_i;
  logic [127:0] rsp_data_o;
  logic [3:0]   rsp_id_o;
  logic         rsp_error_o, rsp_valid_o, rsp_ready_i;

  int vectors = 0;
  int miscompares = 0;

  snitch_icache_refill_writer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .lookup_addr_i(lookup_addr_i), .lookup_id_i(lookup_id_i), .lookup_set_i(lookup_set_i),
    .lookup_hit_i(lookup_hit_i), .lookup_data_i(lookup_data_i), .lookup_error_i(lookup_error_i),
    .lookup_valid_i(lookup_valid_i), .lookup_ready_o(lookup_ready_o),
    .refill_addr_o(refill_addr_o), .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_i(refill_data_i), .refill_error_i(refill_error_i), .refill_valid_i(refill_valid_i),
    .refill_ready_o(refill_ready_o),
    .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
    .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
    .write_ready_i(write_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_error_o(rsp_error_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Full miss: capture, refill request, refill response, write, response. Each valid is
  // held for 'hold' cycles without its ready before the handshake completes.
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] id,
                          input logic [127:0] data, input logic err, input logic flush,
                          input int hold, input logic [0:0] exp_set,
                          input logic [5:0] exp_idx, input logic [21:0] exp_tag);
    step();
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = addr; lookup_id_i = id;
    flush_valid_i = flush; rsp_ready_i = 1'b0;
    #1;
    check("miss_lookup_ready", lookup_ready_o, 1'b1);
    check("miss_no_rsp", rsp_valid_o, 1'b0);
    step();
    lookup_valid_i = 1'b0; flush_valid_i = 1'b0; refill_valid_i = 1'b1;
    for (int k = 0; k < hold; k++) begin
      #1;
      check("req_hold_valid", refill_valid_o, 1'b1);
      check("req_hold_addr", refill_addr_o, {addr[31:4], 4'h0});
      step();
    end
    refill_ready_i = 1'b1;
    #1;
    check("req_valid", refill_valid_o, 1'b1);
    check("req_addr", refill_addr_o, {addr[31:4], 4'h0});
    check("req_ignores_refill", refill_ready_o, 1'b0);
    check("req_stall", lookup_ready_o, 1'b0);
    step();
    refill_ready_i = 1'b0; refill_valid_i = 1'b1; refill_data_i = data; refill_error_i = err;
    #1;
    check("wait_ready", refill_ready_o, 1'b1);
    check("wait_stall", lookup_ready_o, 1'b0);
    step();
    refill_valid_i = 1'b0; refill_data_i = '0; refill_error_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      #1;
      check("wr_hold_valid", write_valid_o, 1'b1);
      check("wr_hold_data", write_data_o, data);
      step();
    end
    write_ready_i = 1'b1;
    #1;
    check("wr_valid", write_valid_o, 1'b1);
    check("wr_addr", write_addr_o, exp_idx);
    check("wr_tag", write_tag_o, exp_tag);
    check("wr_set", write_set_o, exp_set);
    check("wr_data", write_data_o, data);
    check("wr_error", write_error_o, err);
    check("wr_stall", lookup_ready_o, 1'b0);
    step();
    write_ready_i = 1'b0;
    for (int k = 0; k < hold; k++) begin
      #1;
      check("rsp_hold_valid", rsp_valid_o, 1'b1);
      check("rsp_hold_id", rsp_id_o, id);
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    check("rsp_valid", rsp_valid_o, 1'b1);
    check("rsp_id", rsp_id_o, id);
    check("rsp_data", rsp_data_o, data);
    check("rsp_error", rsp_error_o, err);
    check("rsp_stall", lookup_ready_o, 1'b0);
    step();
    rsp_ready_i = 1'b0;
    #1;
    check("back_idle_rsp", rsp_valid_o, 1'b0);
    check("back_idle_flush_ready", flush_ready_o, 1'b1);
  endtask

  initial begin
    rst_i = 1'b1; flush_valid_i = 1'b0;
    lookup_addr_i = '0; lookup_id_i = '0; lookup_set_i = '0; lookup_hit_i = 1'b0;
    lookup_data_i = '0; lookup_error_i = 1'b0; lookup_valid_i = 1'b0;
    refill_ready_i = 1'b0; refill_data_i = '0; refill_error_i = 1'b0; refill_valid_i = 1'b0;
    write_ready_i = 1'b0; rsp_ready_i = 1'b0;

    // Reset state
    #3;
    check("rst_flush_ready", flush_ready_o, 1'b0);
    check("rst_lookup_ready", lookup_ready_o, 1'b0);
    check("rst_refill_valid", refill_valid_o, 1'b0);
    check("rst_write_valid", write_valid_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    step();
    rst_i = 1'b0;
    #1;
    check("idle_flush_ready", flush_ready_o, 1'b1);

    // Hit pass-through, first with the requester stalled
    step();
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b1; lookup_addr_i = 32'h0000_1000;
    lookup_id_i = 4'd3; lookup_set_i = 1'b1; lookup_error_i = 1'b0;
    lookup_data_i = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    #1;
    check("hit_stalled_valid", rsp_valid_o, 1'b1);
    check("hit_stalled_lookup_ready", lookup_ready_o, 1'b0);
    rsp_ready_i = 1'b1;
    #1;
    check("hit_rsp_valid", rsp_valid_o, 1'b1);
    check("hit_rsp_id", rsp_id_o, 4'd3);
    check("hit_rsp_data", rsp_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C);
    check("hit_lookup_ready", lookup_ready_o, 1'b1);
    check("hit_no_refill", refill_valid_o, 1'b0);
    step();
    lookup_valid_i = 1'b0; lookup_hit_i = 1'b0; rsp_ready_i = 1'b0;

    // Miss flow: 0x1234 -> index 0x23, tag 0x1234>>10 = 4, victim 0 (then 1)
    run_miss(32'h0000_1234, 4'd5, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
             1'b0, 1'b0, 0, 1'b0, 6'h23, 22'h000004);
    // Refill error: 0xABC0 -> index 0x3C, tag 0x2A, victim 1 (then 0)
    run_miss(32'h0000_ABC0, 4'd1, 128'hA5A5_A5A5_0000_FFFF_5A5A_5A5A_FFFF_0000,
             1'b1, 1'b0, 0, 1'b1, 6'h3C, 22'h00002A);
    // Backpressure 5 cycles per stage; victim wraps back to 0 (then 1)
    run_miss(32'hFFFF_FFFF, 4'hF, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D,
             1'b0, 1'b0, 5, 1'b0, 6'h3F, 22'h3FFFFF);

    // Flush in IDLE: victim back to 0
    step();
    flush_valid_i = 1'b1;
    #1;
    check("flush_ready", flush_ready_o, 1'b1);
    step();
    flush_valid_i = 1'b0;
    run_miss(32'h2000_0040, 4'd2, 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0F0F_0F0F,
             1'b0, 1'b0, 0, 1'b0, 6'h04, 22'h080000);
    // Flush during capture: uses pre-flush victim 1, next miss gets 0 (then 1)
    run_miss(32'h0000_0010, 4'd7, 128'h7,
             1'b0, 1'b1, 0, 1'b1, 6'h01, 22'h000000);
    run_miss(32'h0000_0400, 4'd8, 128'h8,
             1'b0, 1'b0, 0, 1'b0, 6'h00, 22'h000001);

    // Reset while waiting for the refill response
    step();
    lookup_valid_i = 1'b1; lookup_hit_i = 1'b0; lookup_addr_i = 32'h0000_5550; lookup_id_i = 4'd9;
    step();
    lookup_valid_i = 1'b0; refill_ready_i = 1'b1;
    step();
    refill_ready_i = 1'b0;
    #1;
    check("pre_rst_wait", refill_ready_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_refill_ready", refill_ready_o, 1'b0);
    check("mid_rst_refill_valid", refill_valid_o, 1'b0);
    check("mid_rst_write_valid", write_valid_o, 1'b0);
    check("mid_rst_rsp_valid", rsp_valid_o, 1'b0);
    check("mid_rst_flush_ready", flush_ready_o, 1'b0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("post_rst_idle", flush_ready_o, 1'b1);
    check("post_rst_no_write", write_valid_o, 1'b0);
    // Victim counter cleared by reset (it was 1 before)
    run_miss(32'h0000_0800, 4'd4, 128'h4,
             1'b0, 1'b0, 0, 1'b0, 6'h00, 22'h000002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
